extrema_detect_3d: RTL and testbench
====================================

Name: extrema_detect_3d

Overview:
- Parametrised successor to the fixed 8-bit, max-only 26-neighbour detector in the SIFT detection path.
- Compares a centre DoG sample against its 26 scale-space neighbours (3x3x3 cube minus centre) and flags a strict local maximum and/or minimum.
- Gates each flag with a contrast threshold and a runtime mode select.
- Keeps a saturating per-frame keypoint counter for the downstream descriptor stage.

Parameters:
- DW, 8, sample width in bits, unsigned.
- CNT_W, 16, width of the per-frame extrema counter.

Ports:
- iclk  input  1  system clock.
- irst_n  input  1  asynchronous active-low reset.
- iDval  input  1  input sample set valid.
- iSof  input  1  start-of-frame pulse; clears the counter.
- iCenter  input  DW  centre sample.
- iNbr  input  26*DW  neighbours; neighbour k occupies bits [k*DW +: DW], k=0..25.
- iMode  input  2  bit0 enables max detection, bit1 enables min detection.
- iThrHi  input  DW  max accepted only if iCenter > iThrHi.
- iThrLo  input  DW  min accepted only if iCenter < iThrLo.
- oDval  output  1  output valid, iDval delayed 3 cycles.
- oMax_en  output  1  strict local maximum detected.
- oMin_en  output  1  strict local minimum detected.
- oCnt  output  CNT_W  extrema count in the current frame.
- oCnt_sat  output  1  counter has saturated.

Behaviour:
- Clock and reset: one clock, iclk; asynchronous active-low reset, irst_n. Asserting irst_n low clears every register immediately. Reset values: oDval=0, oMax_en=0, oMin_en=0, oCnt=0, oCnt_sat=0.
- Reset mid-operation: in-flight samples are discarded, with no partial flags after release.
- Pipeline: 3 stages, fixed latency 3, full throughput (one sample set per cycle), no back-pressure.
- Stage 1 (registered):
  - gt[k] = iCenter > nbr[k] and lt[k] = iCenter < nbr[k], for k=0..25.
  - Slot 26 is forced to 1 in both gt and lt.
  - Register thrH = iCenter > iThrHi, thrL = iCenter < iThrLo, the mode bits, and dval.
- Stage 2 (registered): AND the gt vector in 9 groups of 3 (slots 3g..3g+2), and the lt vector likewise.
- Stage 3 (registered):
  - max = AND of 9 gt groups & thrH & mode[0] & dval.
  - min = AND of 9 lt groups & thrL & mode[1] & dval.
- Compare semantics: all compares are unsigned and strict. A centre equal to any neighbour is neither max nor min, so max and min are mutually exclusive. iMode=00 never flags.
- Non-valid cycles: when iDval=0 the flags are forced 0 at that sample's output cycle. Neighbour data is ignored.
- Counter update (on the stage-3 result, next edge):
  - iSof=1 with no detection at stage 3: cnt <= 0, sat <= 0.
  - iSof=1 with a detection (max or min) at stage 3 in the same cycle: cnt <= 1, sat <= 0.
  - Otherwise: cnt increments by 1 per detection. At 2^CNT_W-1 the counter holds, and sat is set and sticky until iSof or reset.
- iSof position: iSof is not pipelined. The frame boundary is taken at the output side. A sample that enters up to 2 cycles before iSof is counted in the new frame.

Optional Feature:
- Macro: EXTREMA_TIE_EN.
- Defined: compares become non-strict (>= / <=), but at least one neighbour must differ strictly.
  - Stage 1 also registers any_ne = OR over k of (iCenter != nbr[k]).
  - max/min each AND with any_ne, so a flat 27-sample plateau flags nothing.
  - A centre tied with some neighbours but above all the others is flagged as a maximum.
  - Latency is unchanged.
- Undefined: strict compares only, and any_ne logic is absent.

Test Plan:
- Reset, then iDval=1, DW=8, iCenter=200, all nbr=100, iThrHi=50, iMode=01 -> 3 cycles later oDval=1, oMax_en=1, oMin_en=0, oCnt=1.
- iCenter=10, all nbr=60, iThrLo=20, iMode=10 -> oMin_en=1 at latency 3. Same sample with iMode=01 -> no flag.
- iCenter=200, nbr[25]=200, others 100 -> no flag without EXTREMA_TIE_EN. With it, oMax_en=1. All 27 samples =200 -> no flag in both builds.
- Threshold gate: iCenter=40, all nbr=30, iThrHi=40 -> oMax_en=0. Change iThrHi to 39 -> oMax_en=1.
- Back-to-back maxima for 5 cycles with a 1-cycle iDval=0 gap -> flags track each sample exactly at latency 3, and oCnt steps 1..5.
- CNT_W=4: 17 detections -> oCnt holds 15 and oCnt_sat=1. iSof coincident with a detection -> oCnt=1, oCnt_sat=0. irst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/extrema_detect_3d.sv
// extrema_detect_3d: flags 26-neighbour scale-space extrema of a DoG centre sample, gated by contrast threshold and mode,
// Latency: 3 cycles from iDval/iCenter/iNbr to oDval/oMax_en/oMin_en; oCnt/oCnt_sat update on the same edge as the flags.
// No back-pressure: one sample set accepted every cycle. Optional macro EXTREMA_TIE_EN: non-strict compares plus any_ne guard.
module extrema_detect_3d #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic               iclk,
  input  logic               irst_n,
  input  logic               iDval,
  input  logic               iSof,
  input  logic [DW-1:0]      iCenter,
  input  logic [26*DW-1:0]   iNbr,
  input  logic [1:0]         iMode,
  input  logic [DW-1:0]      iThrHi,
  input  logic [DW-1:0]      iThrLo,
  output logic               oDval,
  output logic               oMax_en,
  output logic               oMin_en,
  output logic [CNT_W-1:0]   oCnt,
  output logic               oCnt_sat
);

  localparam int NNBR = 26;
  localparam int NGRP = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------- stage 1: per-neighbour compares ----------------
  logic [NNBR:0] w_gt;
  logic [NNBR:0] w_lt;
`ifdef EXTREMA_TIE_EN
  logic          w_any_ne;
`endif

  // Centre-vs-neighbour compare vectors; slot 26 stays 1 so the 27 slots split evenly into 9 groups
  always_comb begin
    w_gt = '1;
    w_lt = '1;
`ifdef EXTREMA_TIE_EN
    w_any_ne = 1'b0;
`endif
    for (int k = 0; k < NNBR; k++) begin
`ifdef EXTREMA_TIE_EN
      w_gt[k]  = (iCenter >= iNbr[k*DW +: DW]);
      w_lt[k]  = (iCenter <= iNbr[k*DW +: DW]);
      w_any_ne = w_any_ne | (iCenter != iNbr[k*DW +: DW]);
`else
      w_gt[k]  = (iCenter > iNbr[k*DW +: DW]);
      w_lt[k]  = (iCenter < iNbr[k*DW +: DW]);
`endif
    end
  end

  logic [NNBR:0] r_gt1;
  logic [NNBR:0] r_lt1;
  logic          r_thrh1;
  logic          r_thrl1;
  logic [1:0]    r_mode1;
  logic          r_dval1;
`ifdef EXTREMA_TIE_EN
  logic          r_any_ne1;
`endif

  // Stage-1 register: compare vectors, threshold results, mode and valid
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_gt1     <= '0;
      r_lt1     <= '0;
      r_thrh1   <= 1'b0;
      r_thrl1   <= 1'b0;
      r_mode1   <= 2'b00;
      r_dval1   <= 1'b0;
`ifdef EXTREMA_TIE_EN
      r_any_ne1 <= 1'b0;
`endif
    end else begin
      r_gt1     <= w_gt;
      r_lt1     <= w_lt;
      r_thrh1   <= (iCenter > iThrHi);
      r_thrl1   <= (iCenter < iThrLo);
      r_mode1   <= iMode;
      r_dval1   <= iDval;
`ifdef EXTREMA_TIE_EN
      r_any_ne1 <= w_any_ne;
`endif
    end
  end

  // ---------------- stage 2: reduce compare vectors in groups of 3 ----------------
  logic [NGRP-1:0] w_gtg;
  logic [NGRP-1:0] w_ltg;

  // Three-input AND per group keeps the stage-2 cone shallow
  always_comb begin
    w_gtg = '0;
    w_ltg = '0;
    for (int g = 0; g < NGRP; g++) begin
      w_gtg[g] = &r_gt1[3*g +: 3];
      w_ltg[g] = &r_lt1[3*g +: 3];
    end
  end

  logic [NGRP-1:0] r_gtg2;
  logic [NGRP-1:0] r_ltg2;
  logic            r_thrh2;
  logic            r_thrl2;
  logic [1:0]      r_mode2;
  logic            r_dval2;
`ifdef EXTREMA_TIE_EN
  logic            r_any_ne2;
`endif

  // Stage-2 register: group reductions plus the side-band gates carried alongside
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_gtg2    <= '0;
      r_ltg2    <= '0;
      r_thrh2   <= 1'b0;
      r_thrl2   <= 1'b0;
      r_mode2   <= 2'b00;
      r_dval2   <= 1'b0;
`ifdef EXTREMA_TIE_EN
      r_any_ne2 <= 1'b0;
`endif
    end else begin
      r_gtg2    <= w_gtg;
      r_ltg2    <= w_ltg;
      r_thrh2   <= r_thrh1;
      r_thrl2   <= r_thrl1;
      r_mode2   <= r_mode1;
      r_dval2   <= r_dval1;
`ifdef EXTREMA_TIE_EN
      r_any_ne2 <= r_any_ne1;
`endif
    end
  end

  // ---------------- stage 3: final decision ----------------
  logic w_max;
  logic w_min;
  logic w_det;

  // Final AND of the groups with threshold, mode and valid; a flat plateau is rejected in the tie build
  always_comb begin
`ifdef EXTREMA_TIE_EN
    w_max = (&r_gtg2) & r_thrh2 & r_mode2[0] & r_dval2 & r_any_ne2;
    w_min = (&r_ltg2) & r_thrl2 & r_mode2[1] & r_dval2 & r_any_ne2;
`else
    w_max = (&r_gtg2) & r_thrh2 & r_mode2[0] & r_dval2;
    w_min = (&r_ltg2) & r_thrl2 & r_mode2[1] & r_dval2;
`endif
    w_det = w_max | w_min;
  end

  logic r_max3;
  logic r_min3;
  logic r_dval3;

  // Stage-3 register drives the flag outputs
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_max3  <= 1'b0;
      r_min3  <= 1'b0;
      r_dval3 <= 1'b0;
    end else begin
      r_max3  <= w_max;
      r_min3  <= w_min;
      r_dval3 <= r_dval2;
    end
  end

  // ---------------- per-frame keypoint counter ----------------
  // iSof is applied unpipelined against the stage-3 decision, so the frame
  // boundary lands on the output side: samples that entered up to 2 cycles
  // before iSof are already counted in the new frame.
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_ONE;

  // Saturating counter: clear/restart on iSof, otherwise count detections and stick at all-ones
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (iSof) begin
      r_cnt <= w_det ? CNT_ONE : '0;
      r_sat <= 1'b0;
    end else if (w_det && (r_cnt != CNT_MAX)) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == CNT_MAX) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign oDval    = r_dval3;
  assign oMax_en  = r_max3;
  assign oMin_en  = r_min3;
  assign oCnt     = r_cnt;
  assign oCnt_sat = r_sat;

endmodule

// File: tb/tb_extrema_detect_3d.sv
// tb_extrema_detect_3d: randomized and directed checks of extrema_detect_3d against a neighbour-counting reference model.
// Two instances share stimulus: default CNT_W=16 and CNT_W=4 for saturation behaviour.
// Every output is compared one time unit after each rising clock edge.
module tb_extrema_detect_3d;

  localparam int DW = 8;

  logic              iclk = 1'b0;
  logic              irst_n;
  logic              iDval;
  logic              iSof;
  logic [DW-1:0]     iCenter;
  logic [26*DW-1:0]  iNbr;
  logic [1:0]        iMode;
  logic [DW-1:0]     iThrHi;
  logic [DW-1:0]     iThrLo;

  logic              oDval, oMax_en, oMin_en, oCnt_sat;
  logic [15:0]       oCnt;
  logic              o4_dval, o4_max, o4_min, o4_sat;
  logic [3:0]        o4_cnt;

  extrema_detect_3d #(.DW(DW), .CNT_W(16)) u_dut (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iSof(iSof), .iCenter(iCenter), .iNbr(iNbr),
    .iMode(iMode), .iThrHi(iThrHi), .iThrLo(iThrLo), .oDval(oDval), .oMax_en(oMax_en),
    .oMin_en(oMin_en), .oCnt(oCnt), .oCnt_sat(oCnt_sat));

  extrema_detect_3d #(.DW(DW), .CNT_W(4)) u_dut4 (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iSof(iSof), .iCenter(iCenter), .iNbr(iNbr),
    .iMode(iMode), .iThrHi(iThrHi), .iThrLo(iThrLo), .oDval(o4_dval), .oMax_en(o4_max),
    .oMin_en(o4_min), .oCnt(o4_cnt), .oCnt_sat(o4_sat));

  always #5 iclk = ~iclk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: classify the centre by counting neighbours below/above/equal.
  function automatic logic [1:0] ref_flags(input logic [7:0] c, input logic [26*8-1:0] n,
                                           input logic [1:0] md, input logic [7:0] hi,
                                           input logic [7:0] lo, input logic dv);
    int nlt = 0;
    int ngt = 0;
    int neq = 0;
    logic [7:0] v;
    bit is_max, is_min;
    for (int k = 0; k < 26; k++) begin
      v = n[k*8 +: 8];
      if (v < c) nlt++;
      else if (v > c) ngt++;
      else neq++;
    end
`ifdef EXTREMA_TIE_EN
    is_max = (ngt == 0) && (neq < 26);
    is_min = (nlt == 0) && (neq < 26);
`else
    is_max = (nlt == 26);
    is_min = (ngt == 26);
`endif
    return {dv && md[1] && (c < lo) && is_min, dv && md[0] && (c > hi) && is_max};
  endfunction

  // Model state: results of the last three accepted sample sets, index 2 oldest.
  bit p_dv[3], p_mx[3], p_mn[3];
  int m_cnt16, m_cnt4;
  bit m_sat16, m_sat4;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      p_dv[i] = 0; p_mx[i] = 0; p_mn[i] = 0;
    end
    m_cnt16 = 0; m_cnt4 = 0; m_sat16 = 0; m_sat4 = 0;
  endtask

  task automatic cnt_upd(input int max_v, input bit det, input bit sof, inout int cnt, inout bit sat);
    if (sof) begin
      cnt = det ? 1 : 0;
      sat = 0;
    end else if (det && cnt < max_v) begin
      cnt = cnt + 1;
      if (cnt == max_v) sat = 1;
    end
  endtask

  // One clock: predict, advance model, compare every output.
  task automatic step();
    logic [1:0] f;
    bit det;
    f = ref_flags(iCenter, iNbr, iMode, iThrHi, iThrLo, iDval);
    @(posedge iclk);
    for (int i = 2; i > 0; i--) begin
      p_dv[i] = p_dv[i-1]; p_mx[i] = p_mx[i-1]; p_mn[i] = p_mn[i-1];
    end
    p_dv[0] = iDval; p_mx[0] = f[0]; p_mn[0] = f[1];
    det = p_mx[2] | p_mn[2];
    cnt_upd(65535, det, iSof, m_cnt16, m_sat16);
    cnt_upd(15, det, iSof, m_cnt4, m_sat4);
    #1;
    check_eq("dval", oDval, p_dv[2]);
    check_eq("max", oMax_en, p_mx[2]);
    check_eq("min", oMin_en, p_mn[2]);
    check_eq("cnt", oCnt, m_cnt16);
    check_eq("sat", oCnt_sat, m_sat16);
    check_eq("cnt4", o4_cnt, m_cnt4);
    check_eq("sat4", o4_sat, m_sat4);
  endtask

  task automatic set_sample(input logic [7:0] c, input logic [7:0] nv, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [1:0] md);
    iDval   = 1'b1;
    iCenter = c;
    for (int k = 0; k < 26; k++) iNbr[k*8 +: 8] = nv;
    iThrHi  = hi;
    iThrLo  = lo;
    iMode   = md;
  endtask

  task automatic idle(input int n);
    iDval = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Present the current sample, drain it to the output, compare flags to constants.
  task automatic run_one(input string tag, input logic emax, input logic emin);
    step();
    iDval = 1'b0;
    step();
    step();
    check_eq({tag, "_max"}, oMax_en, emax);
    check_eq({tag, "_min"}, oMin_en, emin);
    check_eq({tag, "_dval"}, oDval, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dval"}, oDval, 0);
    check_eq({tag, "_max"}, oMax_en, 0);
    check_eq({tag, "_min"}, oMin_en, 0);
    check_eq({tag, "_cnt"}, oCnt, 0);
    check_eq({tag, "_sat"}, oCnt_sat, 0);
    check_eq({tag, "_cnt4"}, o4_cnt, 0);
    check_eq({tag, "_sat4"}, o4_sat, 0);
  endtask

  initial begin
    logic [7:0] c;
    int kind;
    irst_n = 1'b1; iDval = 1'b0; iSof = 1'b0; iCenter = '0; iNbr = '0;
    iMode = 2'b00; iThrHi = '0; iThrLo = '0;
    model_reset();
    #2 irst_n = 1'b0;
    #20;
    check_all_zero("reset");
    irst_n = 1'b1;

    // Plain maximum, first detection of the run
    set_sample(8'd200, 8'd100, 8'd50, 8'd0, 2'b01);
    run_one("max1", 1'b1, 1'b0);
    check_eq("max1_cnt", oCnt, 1);

    // Minimum, then the same sample with only max enabled
    set_sample(8'd10, 8'd60, 8'd255, 8'd20, 2'b10);
    run_one("min1", 1'b0, 1'b1);
    set_sample(8'd10, 8'd60, 8'd255, 8'd20, 2'b01);
    run_one("min_mode01", 1'b0, 1'b0);

    // One tied neighbour, then a flat plateau
    set_sample(8'd200, 8'd100, 8'd50, 8'd255, 2'b11);
    iNbr[25*8 +: 8] = 8'd200;
`ifdef EXTREMA_TIE_EN
    run_one("tie", 1'b1, 1'b0);
`else
    run_one("tie", 1'b0, 1'b0);
`endif
    set_sample(8'd200, 8'd200, 8'd50, 8'd255, 2'b11);
    run_one("flat", 1'b0, 1'b0);

    // Threshold gate boundary
    set_sample(8'd40, 8'd30, 8'd40, 8'd0, 2'b01);
    run_one("thr40", 1'b0, 1'b0);
    set_sample(8'd40, 8'd30, 8'd39, 8'd0, 2'b01);
    run_one("thr39", 1'b1, 1'b0);

    // Back-to-back maxima with one bubble; counter restarts from a fresh frame
    iSof = 1'b1;
    idle(1);
    iSof = 1'b0;
    check_eq("sof_clear", oCnt, 0);
    for (int i = 0; i < 6; i++) begin
      set_sample(8'(150 + i), 8'(20 + i), 8'd10, 8'd0, 2'b01);
      if (i == 2) iDval = 1'b0;
      step();
    end
    idle(3);
    check_eq("b2b_cnt", oCnt, 5);

    // Saturation of the 4-bit counter
    iSof = 1'b1;
    idle(1);
    iSof = 1'b0;
    set_sample(8'd5, 8'd9, 8'd255, 8'd6, 2'b10);
    for (int i = 0; i < 17; i++) step();
    idle(3);
    check_eq("sat_cnt4", o4_cnt, 15);
    check_eq("sat_flag4", o4_sat, 1);
    check_eq("sat_cnt16", oCnt, 17);
    check_eq("sat_flag16", oCnt_sat, 0);

    // iSof coinciding with a detection at the decision stage
    set_sample(8'd220, 8'd1, 8'd0, 8'd0, 2'b01);
    step();
    iDval = 1'b0;
    step();
    iSof = 1'b1;
    step();
    iSof = 1'b0;
    check_eq("sof_det_cnt4", o4_cnt, 1);
    check_eq("sof_det_sat4", o4_sat, 0);
    check_eq("sof_det_cnt", oCnt, 1);

    // Reset with detections in flight
    set_sample(8'd220, 8'd1, 8'd0, 8'd0, 2'b01);
    step();
    step();
    step();
    #2 irst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    #3 irst_n = 1'b1;
    idle(4);

    // Randomized traffic biased towards extrema and ties
    for (int n = 0; n < 1500; n++) begin
      c = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      iCenter = c;
      for (int k = 0; k < 26; k++) begin
        case (kind)
          0:       iNbr[k*8 +: 8] = 8'($urandom_range(0, int'(c)));
          1:       iNbr[k*8 +: 8] = 8'($urandom_range(int'(c), 255));
          2:       iNbr[k*8 +: 8] = 8'($urandom);
          default: iNbr[k*8 +: 8] = ($urandom_range(0, 1) == 0) ? c : (c ^ 8'h01);
        endcase
      end
      iDval  = ($urandom_range(0, 4) != 0);
      iMode  = 2'($urandom_range(0, 3));
      iThrHi = 8'($urandom_range(0, 255));
      iThrLo = 8'($urandom_range(0, 255));
      iSof   = ($urandom_range(0, 49) == 0);
      step();
    end
    iSof = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
